// File: rtl/frequency_counter_mux.sv
// Gated edge counter with a sequential binary-to-BCD converter driving a
// multiplexed seven-segment display with leading-zero blanking and overflow dashes.
module frequency_counter_mux #(
  parameter int UPDATE_PERIOD = 1199,
  parameter int BITS          = 12,
  parameter int DIGITS        = 3,
  parameter int EDGE_BITS     = 10,
  parameter int MUX_BITS      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              signal,
  input  logic [BITS-1:0]   period,
  input  logic              period_load,
  output logic [6:0]        segments,
  output logic [DIGITS-1:0] digit_en,
  output logic              overflow,
  output logic              valid,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(EDGE_BITS + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [EDGE_BITS-1:0] EDGE_MAX = '1;
  localparam logic [31:0] LIMIT = 32'(10**DIGITS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;

  state_e               state_q, state_d;
  logic                 s1_q, s2_q, s3_q;
  logic [BITS-1:0]      period_q, clk_count_q;
  logic [EDGE_BITS-1:0] edge_count_q, edge_next, bin_q, cap_q;
  logic [BCD_W-1:0]     bcd_q, bcd_adj, disp_q;
  logic [CNT_W-1:0]     iter_q;
  logic                 ovf_q, cap_over;
  logic [MUX_BITS-1:0]  mux_q;
  logic [1:0]           idx_q;
  logic                 edge_seen, window_end, load_capture, blank;
  logic [3:0]           nibble;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= signal;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_seen  = s2_q & ~s3_q;
  assign edge_next  = (edge_seen && edge_count_q != EDGE_MAX) ? edge_count_q + 1'b1 : edge_count_q;
  assign window_end = !period_load && (clk_count_q == period_q);

  // A load restarts the window without producing a capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q     <= BITS'(UPDATE_PERIOD);
      clk_count_q  <= '0;
      edge_count_q <= '0;
    end else if (period_load) begin
      period_q     <= period;
      clk_count_q  <= '0;
      edge_count_q <= '0;
    end else if (window_end) begin
      clk_count_q  <= '0;
      edge_count_q <= '0;
    end else begin
      clk_count_q  <= clk_count_q + 1'b1;
      edge_count_q <= edge_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Window ends seen outside IDLE are simply dropped.
  always_comb begin
    state_d      = state_q;
    load_capture = 1'b0;
    case (state_q)
      IDLE: if (window_end) begin
        state_d      = SHIFT;
        load_capture = 1'b1;
      end
      SHIFT: if (iter_q == CNT_W'(EDGE_BITS - 1)) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q  <= '0;
      cap_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
    end else if (load_capture) begin
      bin_q  <= edge_next;
      cap_q  <= edge_next;
      bcd_q  <= '0;
      iter_q <= '0;
    end else if (state_q == SHIFT) begin
      bcd_q  <= {bcd_adj[BCD_W-2:0], bin_q[EDGE_BITS-1]};
      bin_q  <= {bin_q[EDGE_BITS-2:0], 1'b0};
      iter_q <= iter_q + 1'b1;
    end
  end

  // Truncated BCD keeps the low digits exact; out-of-range values show dashes anyway.
  assign cap_over = {{(32-EDGE_BITS){1'b0}}, cap_q} > LIMIT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q <= '0;
      ovf_q  <= 1'b0;
    end else if (state_q == DONE) begin
      disp_q <= bcd_q;
      ovf_q  <= cap_over;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mux_q <= '0;
      idx_q <= '0;
    end else begin
      mux_q <= mux_q + 1'b1;
      if (&mux_q) idx_q <= (idx_q == 2'(DIGITS - 1)) ? 2'd0 : idx_q + 2'd1;
    end
  end

  assign nibble = disp_q[{idx_q, 2'b00} +: 4];
  assign blank  = (idx_q != 2'd0) && ((disp_q >> {idx_q, 2'b00}) == '0);

  always_comb begin
    digit_en        = '0;
    digit_en[idx_q] = 1'b1;
    segments        = 7'h00;
    if (ovf_q) segments = 7'h40;
    else if (!blank) begin
      case (nibble)
        4'd0: segments = 7'h3F;
        4'd1: segments = 7'h06;
        4'd2: segments = 7'h5B;
        4'd3: segments = 7'h4F;
        4'd4: segments = 7'h66;
        4'd5: segments = 7'h6D;
        4'd6: segments = 7'h7D;
        4'd7: segments = 7'h07;
        4'd8: segments = 7'h7F;
        4'd9: segments = 7'h6F;
        default: segments = 7'h00;
      endcase
    end
  end

  assign overflow  = ovf_q;
  assign valid     = (state_q == DONE);
  assign dbg_state = state_q;

endmodule
